// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: widths, state encoding, branch-target LUT.
package fetch_pkg;

   localparam int unsigned D     = 10;
   localparam int unsigned L     = 5;
   localparam int unsigned OFF_W = 6;
   localparam int unsigned LUT_N = 2 ** L;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Absolute jump targets shared with the assembler; entry 3 is the canonical 100.
   localparam logic [D-1:0] BRANCH_LUT [LUT_N] = '{
      10'd0,    10'd16,   10'd48,   10'd100,
      10'd128,  10'd160,  10'd200,  10'd256,
      10'd300,  10'd320,  10'd384,  10'd400,
      10'd448,  10'd500,  10'd512,  10'd576,
      10'd600,  10'd640,  10'd700,  10'd704,
      10'd768,  10'd800,  10'd832,  10'd896,
      10'd900,  10'd960,  10'd1000, 10'd1008,
      10'd1016, 10'd1020, 10'd1022, 10'd1023
   };

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch-target lookup from the shared constant table.
module branch_lut
   import fetch_pkg::*;
(
   input  logic [L-1:0] idx,
   output logic [D-1:0] target_c
);

   // Pure table read; no state.
   always_comb begin
      target_c = BRANCH_LUT[idx];
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer feeding the instruction ROM.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned CW = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             branch_en,
   input  logic [OFF_W-1:0] branch_off,
   input  logic             jump_en,
   input  logic [L-1:0]     jump_idx,
   output logic [D-1:0]     prog_ctr,
   output logic             running,
   output logic             done,
   output logic [CW-1:0]    fetch_cnt
);

   state_e          state_q, state_d;
   logic [D-1:0]    prog_ctr_q, prog_ctr_d;
   logic [CW-1:0]   fetch_cnt_q, fetch_cnt_d;
   logic            running_q, running_d;
   logic            done_q, done_d;
   logic [D-1:0]    lut_target_c;
   logic [D-1:0]    off_ext;
   logic [CW-1:0]   cnt_inc;

   branch_lut u_branch_lut (
      .idx      (jump_idx),
      .target_c (lut_target_c)
   );

   // Sign-extended branch offset and saturating retire count.
   always_comb begin
      off_ext = {{(D - OFF_W){branch_off[OFF_W-1]}}, branch_off};
      cnt_inc = (fetch_cnt_q == {CW{1'b1}}) ? fetch_cnt_q : fetch_cnt_q + CW'(1);
   end

   // Next-state and next-PC selection: start > stall > halt > jump > branch > increment.
   always_comb begin
      state_d     = state_q;
      prog_ctr_d  = prog_ctr_q;
      fetch_cnt_d = fetch_cnt_q;
      if (start) begin
         state_d     = RUN;
         prog_ctr_d  = '0;
         fetch_cnt_d = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (!stall) begin
                  fetch_cnt_d = cnt_inc;
                  if (halt_req) begin
                     state_d = DONE;
                  end else if (jump_en) begin
                     prog_ctr_d = lut_target_c;
                  end else if (branch_en) begin
                     prog_ctr_d = prog_ctr_q + off_ext;
                  end else begin
                     prog_ctr_d = prog_ctr_q + D'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
      running_d = (state_d == RUN);
      done_d    = (state_d == DONE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         prog_ctr_q  <= '0;
         fetch_cnt_q <= '0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prog_ctr_q  <= prog_ctr_d;
         fetch_cnt_q <= fetch_cnt_d;
         running_q   <= running_d;
         done_q      <= done_d;
      end
   end

   assign prog_ctr  = prog_ctr_q;
   assign running   = running_q;
   assign done      = done_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus, queued expectations, edge-offset monitor.
module tb_fetch_ctrl;

   logic       clk = 1'b0;
   logic       reset_n, start, stall, halt_req, branch_en, jump_en;
   logic [5:0] branch_off;
   logic [4:0] jump_idx;

   logic [9:0]  pc, pc4;
   logic        run, run4, dn, dn4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   typedef struct {
      int          at_cyc;
      string       nm;
      logic [9:0]  pc;
      logic        run;
      logic        dn;
      logic [15:0] cnt;
      logic        chk4;
      logic [3:0]  c4;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.CW(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt_req(halt_req),
      .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en), .jump_idx(jump_idx),
      .prog_ctr(pc), .running(run), .done(dn), .fetch_cnt(cnt)
   );

   fetch_ctrl #(.CW(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt_req(halt_req),
      .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en), .jump_idx(jump_idx),
      .prog_ctr(pc4), .running(run4), .done(dn4), .fetch_cnt(cnt4)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: after each edge, compare every expectation due at this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at_cyc != cyc || pc !== e.pc || run !== e.run || dn !== e.dn || cnt !== e.cnt ||
                pc4 !== e.pc || run4 !== e.run || dn4 !== e.dn || (e.chk4 && cnt4 !== e.c4)) begin
               failures++;
               $display("FAIL %s @cyc %0d: got pc=%0d run=%0b done=%0b cnt=%0d pc4=%0d run4=%0b done4=%0b cnt4=%0d, want pc=%0d run=%0b done=%0b cnt=%0d cnt4=%0d(chk=%0b) due@%0d",
                        e.nm, cyc, pc, run, dn, cnt, pc4, run4, dn4, cnt4,
                        e.pc, e.run, e.dn, e.cnt, e.c4, e.chk4, e.at_cyc);
            end
         end
      end
   end

   task automatic step(input logic rn, input logic st, input logic stl, input logic hr,
                       input logic be, input logic [5:0] bo, input logic je, input logic [4:0] ji);
      reset_n = rn; start = st; stall = stl; halt_req = hr;
      branch_en = be; branch_off = bo; jump_en = je; jump_idx = ji;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0);
   endtask

   task automatic push(input string nm, input logic [9:0] p, input logic r, input logic d,
                       input logic [15:0] c, input logic k4, input logic [3:0] c4);
      exp_t e;
      e.at_cyc = cyc + 1; e.nm = nm; e.pc = p; e.run = r; e.dn = d;
      e.cnt = c; e.chk4 = k4; e.c4 = c4;
      sb.push_back(e);
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   initial begin
      // Reset for two edges.
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 5'd3); adv();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0);
      push("reset", 10'd0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0); adv();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0);
      push("start", 10'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0); adv();

      // Twenty sequential fetches; CW=4 instance saturates at 15.
      for (int i = 1; i <= 20; i++) begin
         idle();
         if (i == 1)  push("inc1",  10'd1,  1'b1, 1'b0, 16'd1,  1'b1, 4'd1);
         if (i == 10) push("inc10", 10'd10, 1'b1, 1'b0, 16'd10, 1'b1, 4'd10);
         if (i == 15) push("inc15", 10'd15, 1'b1, 1'b0, 16'd15, 1'b1, 4'd15);
         if (i == 20) push("sat4",  10'd20, 1'b1, 1'b0, 16'd20, 1'b1, 4'd15);
         adv();
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111011, 1'b0, 5'd0);
      push("br_m5", 10'd15, 1'b1, 1'b0, 16'd21, 1'b1, 4'd15); adv();

      // Restart, held start keeps PC pinned, then offset-zero self loop.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0);
      push("restart", 10'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0); adv();
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd9, 1'b1, 5'd3);
      push("start_hold", 10'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 5'd0);
      push("br_zero", 10'd0, 1'b1, 1'b0, 16'd1, 1'b0, 4'd0); adv();
      idle(); adv();
      idle(); push("pc2", 10'd2, 1'b1, 1'b0, 16'd3, 1'b0, 4'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111011, 1'b0, 5'd0);
      push("br_wrap", 10'd1021, 1'b1, 1'b0, 16'd4, 1'b0, 4'd0); adv();
      idle(); adv();
      idle(); push("pc1023", 10'd1023, 1'b1, 1'b0, 16'd6, 1'b0, 4'd0); adv();
      idle(); push("inc_wrap", 10'd0, 1'b1, 1'b0, 16'd7, 1'b0, 4'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111111, 1'b0, 5'd0);
      push("br_neg1_wrap", 10'd1023, 1'b1, 1'b0, 16'd8, 1'b0, 4'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 5'd3);
      push("jump_wins", 10'd100, 1'b1, 1'b0, 16'd9, 1'b0, 4'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b011111, 1'b0, 5'd0);
      push("br_p31", 10'd131, 1'b1, 1'b0, 16'd10, 1'b0, 4'd0); adv();

      // Stall at PC 7 masks halt and jump; halt taken once stall drops.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0);
      push("restart2", 10'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0); adv();
      for (int i = 1; i <= 7; i++) begin
         idle();
         if (i == 7) push("pc7", 10'd7, 1'b1, 1'b0, 16'd7, 1'b1, 4'd7);
         adv();
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 5'd3);
         push("stall", 10'd7, 1'b1, 1'b0, 16'd7, 1'b1, 4'd7); adv();
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 5'd0);
      push("halt_after_stall", 10'd7, 1'b0, 1'b1, 16'd8, 1'b1, 4'd8); adv();

      // Halt at PC 50 (0 +31 +19), then DONE ignores everything but start.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0);
      push("start_from_done", 10'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b011111, 1'b0, 5'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b010011, 1'b0, 5'd0);
      push("pc50", 10'd50, 1'b1, 1'b0, 16'd2, 1'b0, 4'd0); adv();
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 5'd3);
      push("halt50", 10'd50, 1'b0, 1'b1, 16'd3, 1'b1, 4'd3); adv();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, i[0], i[1], 1'b1, 6'(i), 1'b1, 5'(i));
         push("done_hold", 10'd50, 1'b0, 1'b1, 16'd3, 1'b1, 4'd3); adv();
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd0);
      push("restart_done", 10'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0); adv();

      // Jump to 300, then mid-run reset returns to IDLE and stays there.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 5'd8);
      push("jump300", 10'd300, 1'b1, 1'b0, 16'd1, 1'b1, 4'd1); adv();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 1'b1, 5'd9);
      push("mid_reset", 10'd0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0); adv();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, i[0], 1'b1, 6'd7, i[1], 5'd8);
         push("idle_hold", 10'd0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0); adv();
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && sb.size() > 0; i++) adv();
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and fetch-sequencing stage that sits directly upstream of the instruction ROM.
- Drives the D-bit ROM address every cycle and sequences it from control inputs supplied by the decode/ALU stage: increment, relative branch, LUT-based absolute jump, stall and halt.
- Owns the start/done handshake with the testbench/top level and a retired-fetch counter.

Parameters:
D, 10, PC / ROM address width; address space 2**D words.
L, 5, branch-target LUT index width; 2**L entries.
CW, 16, width of retired-fetch counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
start  input  1  level; high on a clock edge (re)starts the program from address 0.
stall  input  1  hold PC this cycle (downstream not ready).
halt_req  input  1  current instruction is HALT.
branch_en  input  1  current instruction is a relative branch and its condition is true.
branch_off  input  6  signed two's-complement relative offset, range -32..+31.
jump_en  input  1  current instruction is an absolute jump.
jump_idx  input  L  index into branch-target LUT.
prog_ctr  output  D  address to instruction ROM.
running  output  1  high in RUN state.
done  output  1  high in DONE state; sticky until start or reset.
fetch_cnt  output  CW  instructions retired since last start, saturating.

Behaviour:
- Registers: state {IDLE, RUN, DONE}, prog_ctr, fetch_cnt. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- Reset (reset_n=0 at an edge): state=IDLE, prog_ctr=0, fetch_cnt=0, running=0, done=0. Reset overrides every other input, including mid-RUN.
- Per-edge priority: reset > start > stall > halt_req > jump_en > branch_en > increment.
- start=1 in any state: prog_ctr<=0, fetch_cnt<=0, state<=RUN, done<=0.
  - Start held high keeps the PC pinned at 0.
  - Execution begins on the first edge after start falls.
  - The ROM sees address 0 in the cycle after start is first sampled.
- IDLE: prog_ctr holds. The only exit is start.
- RUN, with start=0:
  - stall=1: prog_ctr and fetch_cnt hold. halt/jump/branch are ignored that cycle; the decoder must re-present them.
  - halt_req=1: state<=DONE; prog_ctr holds (still points at the HALT word); fetch_cnt+1.
  - jump_en=1: prog_ctr<=lut[jump_idx]; fetch_cnt+1.
  - branch_en=1: prog_ctr<=prog_ctr+sext(branch_off); fetch_cnt+1.
  - otherwise: prog_ctr<=prog_ctr+1; fetch_cnt+1.
  - If jump_en and branch_en are both high, jump wins.
- Arithmetic is modulo 2**D:
  - 2**D-1 +1 wraps to 0.
  - 0 + (-1) wraps to 2**D-1.
  - A branch offset of 0 is a legal self-loop.
- fetch_cnt saturates at 2**CW-1; it never wraps.
- DONE: done=1, running=0, prog_ctr holds. All control inputs except start and reset are ignored.
- Latency: a control input sampled at edge N is reflected on prog_ctr after edge N (visible in cycle N+1). The ROM is combinational, so the instruction at the new PC is available in that same cycle.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam widths (D, L, offset width 6);
  - the branch-target LUT contents as a constant array of 2**L D-bit addresses, so assembler and RTL share one source.
- One sub-module, branch_lut: combinational, L-bit index in, D-bit target out, reading the package constant.
- Everything else stays in fetch_ctrl.

Test Plan:
- Reset/start: hold reset_n=0 for 2 cycles, then start=1 for 1 cycle -> prog_ctr=0, running=1, done=0. Ten idle cycles -> prog_ctr=10, fetch_cnt=10.
- Branch: at prog_ctr=20, branch_en=1, branch_off=6'b111011 (-5) -> prog_ctr=15. At prog_ctr=2, branch_off=-5 -> prog_ctr=1021 (wrap, D=10).
- Jump vs branch: with lut[3]=100, assert jump_en=1, jump_idx=3 and branch_en=1 together -> prog_ctr=100.
- Stall: stall=1 for 3 cycles at prog_ctr=7, with halt_req=1 also high -> prog_ctr stays 7, fetch_cnt unchanged, state stays RUN. Drop stall -> halt is taken on the next edge.
- Halt/done: halt_req=1 at prog_ctr=50 -> done=1, prog_ctr=50, held for 20 cycles regardless of jump/branch. Then start=1 -> done=0, prog_ctr=0, fetch_cnt=0.
- Mid-run reset and saturation:
  - reset_n=0 while at prog_ctr=300 -> IDLE, prog_ctr=0 on the next edge.
  - With CW overridden to 4, run 20 increments -> fetch_cnt saturates at 15.
